router_out_arbiter: RTL and testbench

//  Per-output-port round-robin arbiter for the 8x8 serial router; one instance per output.

---
 rtl/router_out_arbiter.sv | 130 +++++++++++++
 tb/tb_router_out_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arbiter.sv
// Per-output round-robin arbiter for the 8x8 serial router: holds a one-hot grant for a
// whole packet and releases it on end-of-packet, source abort or a silence timeout.
module router_out_arbiter #(
    parameter  int NPORTS  = 8,
    parameter  int TIMEOUT = 64,
    localparam int IDXW    = $clog2(NPORTS),
    localparam int CNTW    = $clog2(TIMEOUT)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] frame_n,
    input  logic [NPORTS-1:0] valid_n,
    output logic [NPORTS-1:0] grant,
    output logic [IDXW-1:0]   grant_idx,
    output logic              busy,
    output logic              timeout_err,
    output logic              dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Handshake: a requester raises req[i] and holds it until its packet ends; the arbiter
    // answers with grant[i] one edge later and keeps it until release. Dropping req[i] while
    // granted is an abort; requests of non-granted ports simply wait.

    state_t            r_state;
    logic [NPORTS-1:0] r_grant;
    logic [IDXW-1:0]   r_grant_idx;
    logic [IDXW-1:0]   r_ptr;
    logic [CNTW-1:0]   r_cnt;
    logic              r_timeout_err;

    state_t            w_state_nxt;
    logic [NPORTS-1:0] w_grant_nxt;
    logic [IDXW-1:0]   w_grant_idx_nxt;
    logic [IDXW-1:0]   w_ptr_nxt;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic              w_timeout_err_nxt;

    logic              w_found;
    logic [IDXW-1:0]   w_win;
    logic [IDXW-1:0]   w_scan;
    logic              w_eop;
    logic              w_abort;
    logic              w_timeout;

    // Descending scan so the requester closest to r_ptr (in wrap order) is assigned last.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_scan  = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            w_scan = r_ptr + IDXW'(k);
            if (req[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
        end
    end

    assign w_eop     = !valid_n[r_grant_idx] && frame_n[r_grant_idx];
    assign w_abort   = !req[r_grant_idx];
    assign w_timeout = (r_cnt == CNTW'(TIMEOUT - 1)) && valid_n[r_grant_idx];

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_idx_nxt   = r_grant_idx;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt          = S_BUSY;
                    w_grant_nxt          = '0;
                    w_grant_nxt[w_win]   = 1'b1;
                    w_grant_idx_nxt      = w_win;
                    w_cnt_nxt            = '0;
                end
            end
            S_BUSY: begin
                if (w_eop || w_abort || w_timeout) begin
                    // End-of-packet wins over a simultaneous abort, so no error in that case.
                    w_state_nxt       = S_IDLE;
                    w_grant_nxt       = '0;
                    w_grant_idx_nxt   = '0;
                    w_ptr_nxt         = r_grant_idx + IDXW'(1);
                    w_cnt_nxt         = '0;
                    w_timeout_err_nxt = !w_eop && !w_abort;
                end else begin
                    w_cnt_nxt = valid_n[r_grant_idx] ? r_cnt + CNTW'(1) : '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign busy        = |r_grant;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = (r_state == S_BUSY);

endmodule

// File: tb/tb_router_out_arbiter.sv
// Bench for router_out_arbiter: directed packet traffic, an ownership-level reference model
// compared every cycle, and a queue of expected grant order filled by each test.
module tb_router_out_arbiter;

    localparam int NPORTS  = 8;
    localparam int TIMEOUT = 64;
    localparam int IDXW    = 3;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NPORTS-1:0] req = '0;
    logic [NPORTS-1:0] frame_n = '1;
    logic [NPORTS-1:0] valid_n = '1;
    logic [NPORTS-1:0] grant;
    logic [IDXW-1:0]   grant_idx;
    logic              busy;
    logic              timeout_err;
    logic              dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [IDXW-1:0] exp_q[$];

    router_out_arbiter #(.NPORTS(NPORTS), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .frame_n     (frame_n),
        .valid_n     (valid_n),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic do_reset();
        req     = '0;
        frame_n = '1;
        valid_n = '1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks only who owns the output, whose turn is next, and how long the owner has been silent.
    int m_owner  = -1;
    int m_next   = 0;
    int m_silent = 0;
    bit m_to     = 1'b0;

    function automatic int first_req(input logic [NPORTS-1:0] r, input int from);
        for (int k = 0; k < NPORTS; k++)
            if (r[(from + k) % NPORTS]) return (from + k) % NPORTS;
        return -1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_owner  = -1;
            m_next   = 0;
            m_silent = 0;
            m_to     = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                m_owner  = first_req(req, m_next);
                m_silent = 0;
            end else begin
                bit last_bit, quit, silent_out;
                last_bit   = !valid_n[m_owner] && frame_n[m_owner];
                quit       = !req[m_owner];
                silent_out = valid_n[m_owner] && (m_silent + 1 >= TIMEOUT);
                if (last_bit || quit || silent_out) begin
                    m_to    = silent_out && !last_bit && !quit;
                    m_next  = (m_owner + 1) % NPORTS;
                    m_owner = -1;
                end else begin
                    m_silent = valid_n[m_owner] ? m_silent + 1 : 0;
                end
            end
        end
    end

    // ---------------- compare / scoreboard ----------------
    logic [NPORTS-1:0] prev_grant = '0;

    always @(posedge clock) begin
        logic [NPORTS-1:0] e_grant;
        #2;
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        chk("cyc_grant", 32'(grant), 32'(e_grant));
        chk("cyc_grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
        chk("cyc_timeout_err", 32'(timeout_err), 32'(m_to));
        if (grant != '0 && prev_grant == '0) begin
            if (exp_q.size() == 0) begin
                chk("grant_order_unexpected", 32'(grant_idx), 32'hFFFF_FFFF);
            end else begin
                logic [IDXW-1:0] e_idx;
                e_idx = exp_q.pop_front();
                chk("grant_order", 32'(grant_idx), 32'(e_idx));
            end
        end
        prev_grant = grant;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) chk("wait_busy_timeout", 32'(busy), 32'd1);
    endtask

    // Called on the negedge where grant[p] is already visible; returns on the negedge after release.
    task automatic drive_packet(input int p, input int nbits, input bit drop_last, input int abort_at);
        bit aborted;
        aborted = 1'b0;
        for (int c = 0; c < 14; c++) begin
            frame_n[p] = 1'b0;
            valid_n[p] = 1'b1;
            @(negedge clock);
        end
        for (int b = 0; b < nbits && !aborted; b++) begin
            if (b == abort_at) begin
                req[p]     = 1'b0;
                valid_n[p] = 1'b1;
                frame_n[p] = 1'b1;
                aborted    = 1'b1;
            end else begin
                valid_n[p] = 1'b0;
                frame_n[p] = (b == nbits - 1);
                if (b == nbits - 1 && drop_last) req[p] = 1'b0;
            end
            @(negedge clock);
        end
        valid_n[p] = 1'b1;
        frame_n[p] = 1'b1;
        req[p]     = 1'b0;
    endtask

    task automatic serve(input int npkts, input bit drop_last);
        bit ok;
        int p;
        for (int i = 0; i < npkts; i++) begin
            wait_busy(ok);
            if (!ok) return;
            p = int'(grant_idx);
            drive_packet(p, 32, drop_last, -1);
            chk("release_grant", 32'(grant), 32'd0);
            chk("release_busy", 32'(busy), 32'd0);
            chk("release_no_err", 32'(timeout_err), 32'd0);
            if (i < npkts - 1) begin
                @(negedge clock);
                chk("one_idle_gap", 32'(busy), 32'd1);
            end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bit ok;
        int n;

        repeat (2) @(negedge clock);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_grant_idx", 32'(grant_idx), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // T1 single packet on port 0
        exp_q.push_back(3'd0);
        req = 8'h01;
        @(negedge clock);
        chk("t1_grant_latency", 32'(grant), 32'h01);
        serve(1, 1'b0);
        // ptr now 1: port 1 must beat port 0
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        req = 8'h03;
        @(negedge clock);
        chk("t1_ptr_is_1", 32'(grant_idx), 32'd1);
        serve(2, 1'b0);

        // T2 round robin from ptr 0
        do_reset();
        foreach (exp_q[i]) chk("t2_queue_drained", 32'(exp_q[i]), 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) exp_q.push_back(IDXW'(i));
        req = 8'h0F;
        @(negedge clock);
        chk("t2_first_grant", 32'(grant), 32'h01);
        serve(4, 1'b0);

        // T3 wrap: port 6 packet leaves ptr at 7
        exp_q.push_back(3'd6);
        req = 8'h40;
        serve(1, 1'b0);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        req = 8'h81;
        @(negedge clock);
        chk("t3_port7_first", 32'(grant), 32'h80);
        serve(2, 1'b0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        req = 8'h83;
        @(negedge clock);
        chk("t3_ptr_is_1", 32'(grant_idx), 32'd1);
        serve(3, 1'b0);

        // T4 timeout on port 2 (ptr is 1 here)
        exp_q.push_back(3'd2);
        req = 8'h04;
        @(negedge clock);
        chk("t4_grant", 32'(grant), 32'h04);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk("t4_busy_cycles", 32'(n), 32'd64);
        chk("t4_err_pulse", 32'(timeout_err), 32'd1);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd2);
        req[3] = 1'b1;
        @(negedge clock);
        chk("t4_err_one_cycle", 32'(timeout_err), 32'd0);
        chk("t4_regrant_ptr3", 32'(grant), 32'h08);
        serve(2, 1'b0);

        // T5 abort colliding with last bit, then abort mid-payload
        exp_q.push_back(3'd5);
        req = 8'h20;
        serve(1, 1'b1);
        exp_q.push_back(3'd5);
        req = 8'h20;
        @(negedge clock);
        wait_busy(ok);
        if (ok) begin
            drive_packet(5, 32, 1'b0, 5);
            chk("t5_abort_grant", 32'(grant), 32'd0);
            chk("t5_abort_no_err", 32'(timeout_err), 32'd0);
            @(negedge clock);
            chk("t5_abort_no_err_late", 32'(timeout_err), 32'd0);
        end

        // T6 reset mid-packet on port 4
        exp_q.push_back(3'd4);
        req = 8'h10;
        @(negedge clock);
        wait_busy(ok);
        if (ok) begin
            for (int c = 0; c < 14; c++) begin
                frame_n[4] = 1'b0;
                valid_n[4] = 1'b1;
                @(negedge clock);
            end
            for (int b = 0; b < 10; b++) begin
                frame_n[4] = 1'b0;
                valid_n[4] = 1'b0;
                @(negedge clock);
            end
            frame_n[4] = 1'b0;
            valid_n[4] = 1'b0;
            #2 reset_n = 1'b0;
            #1;
            chk("t6_async_grant", 32'(grant), 32'd0);
            chk("t6_async_grant_idx", 32'(grant_idx), 32'd0);
            chk("t6_async_busy", 32'(busy), 32'd0);
            req     = '0;
            frame_n = '1;
            valid_n = '1;
            @(negedge clock);
            reset_n = 1'b1;
            exp_q.push_back(3'd4);
            req = 8'h10;
            @(negedge clock);
            chk("t6_regrant", 32'(grant), 32'h10);
            serve(1, 1'b0);
        end

        repeat (3) @(negedge clock);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL global_time_limit: got %0t expected finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
